pc_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer for the 9-bit accumulator core. It owns the program counter, fetches instructions over a request/valid handshake, and holds each instruction for the decoder. It issues one-cycle execute and memory strobes that gate architectural writes, resolves relative, conditional and absolute branches, and runs a start/done handshake with the testbench.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/jump_lut.sv | 16 +
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit accumulator core: sequencer states, opcodes, operand width.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StMem,
    StHalt
  } seq_state_t;

  localparam int unsigned OPERAND_W = 4;

  localparam logic [4:0] OP_LOADM  = 5'd17;
  localparam logic [4:0] OP_STOREM = 5'd19;
  localparam logic [4:0] OP_BEQ    = 5'd22;
  localparam logic [4:0] OP_RB     = 5'd23;
  localparam logic [4:0] OP_AB     = 5'd24;
  localparam logic [4:0] OP_DONE   = 5'd31;

endpackage

// File: rtl/jump_lut.sv
// Absolute-branch target table: 16 fixed PC targets indexed by the instruction operand.
module jump_lut #(
  parameter int unsigned PC_W = 10
) (
  input  logic [3:0]      i_idx,
  output logic [PC_W-1:0] o_target
);

  localparam logic [9:0] LUT_INIT [16] = '{
    10'h000, 10'h040, 10'h120, 10'h0c0, 10'h100, 10'h140, 10'h180, 10'h1c0,
    10'h200, 10'h240, 10'h280, 10'h2c0, 10'h300, 10'h340, 10'h380, 10'h3ff
  };

  assign o_target = PC_W'(LUT_INIT[i_idx]);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the PC and issuing exec/mem strobes.
// Optional run-length counter built only when SEQ_CYCLE_COUNT_EN is defined.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             imem_valid,
  input  logic [8:0]       imem_data,
  input  logic             dec_dat_write,
  input  logic             dec_acc_src,
  input  logic             dec_compare,
  input  logic             dec_reljump,
  input  logic             dec_absjump,
  input  logic             dec_done,
  input  logic             eq_flag,
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  output logic [8:0]       instr_q,
  output logic             exec_stb,
  output logic             mem_stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  seq_state_t      r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [8:0]      r_instr;
  logic [PC_W-1:0] w_jump_target;
  logic [PC_W-1:0] w_rel_off;
  logic            w_start_ok;

  jump_lut #(
    .PC_W (PC_W)
  ) u_jump_lut (
    .i_idx    (r_instr[3:0]),
    .o_target (w_jump_target)
  );

  assign w_rel_off  = {{(PC_W-OPERAND_W){r_instr[OPERAND_W-1]}}, r_instr[OPERAND_W-1:0]};
  assign w_start_ok = start & ((r_state == StIdle) | (r_state == StHalt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pc    <= START_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == StWait && imem_valid) r_instr <= imem_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StHalt: if (start) w_state_next = StFetch;
      StFetch:        w_state_next = StWait;
      StWait:         if (imem_valid) w_state_next = StExec;
      StExec: begin
        if (dec_done)                         w_state_next = StHalt;
        else if (dec_dat_write | ~dec_acc_src) w_state_next = StMem;
        else                                  w_state_next = StFetch;
      end
      StMem:          w_state_next = StFetch;
      default:        w_state_next = StIdle;
    endcase
  end

  // PC only moves on an accepted start or on the edge leaving EXEC.
  always_comb begin
    w_pc_next = r_pc;
    if (w_start_ok) begin
      w_pc_next = START_PC;
    end else if (r_state == StExec) begin
      if (dec_done)                                      w_pc_next = r_pc;
      else if (dec_absjump)                              w_pc_next = w_jump_target;
      else if (dec_reljump & (~dec_compare | eq_flag))   w_pc_next = r_pc + w_rel_off;
      else                                               w_pc_next = r_pc + 1'b1;
    end
  end

  always_comb begin
    imem_req = 1'b0;
    exec_stb = 1'b0;
    mem_stb  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      StFetch: begin imem_req = 1'b1; busy = 1'b1; end
      StWait:  busy = 1'b1;
      StExec:  begin exec_stb = 1'b1; busy = 1'b1; end
      StMem:   begin mem_stb  = 1'b1; busy = 1'b1; end
      StHalt:  done = 1'b1;
      default: ;
    endcase
  end

  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign instr_q   = r_instr;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycle_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
    end else if (w_start_ok) begin
      r_cycle_count <= '0;
    end else if (busy && r_cycle_count != {CNT_W{1'b1}}) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a tiny opcode decoder driving the dec_* inputs.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             imem_valid = 1'b0;
  logic [8:0]       imem_data = '0;
  logic             eq_flag = 1'b0;
  logic             dec_dat_write, dec_acc_src, dec_compare, dec_reljump, dec_absjump, dec_done;
  logic [PC_W-1:0]  pc, imem_addr;
  logic             imem_req, exec_stb, mem_stb, busy, done;
  logic [8:0]       instr_q;
  logic [CNT_W-1:0] cycle_count;
  logic [4:0]       opcode;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .PC_W     (PC_W),
    .START_PC ('0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .dec_dat_write (dec_dat_write),
    .dec_acc_src   (dec_acc_src),
    .dec_compare   (dec_compare),
    .dec_reljump   (dec_reljump),
    .dec_absjump   (dec_absjump),
    .dec_done      (dec_done),
    .eq_flag       (eq_flag),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .instr_q       (instr_q),
    .exec_stb      (exec_stb),
    .mem_stb       (mem_stb),
    .busy          (busy),
    .done          (done),
    .cycle_count   (cycle_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    opcode        = instr_q[8:4];
    dec_dat_write = (opcode == OP_STOREM);
    dec_acc_src   = (opcode != OP_LOADM);
    dec_compare   = (opcode == OP_BEQ);
    dec_reljump   = (opcode == OP_BEQ) || (opcode == OP_RB);
    dec_absjump   = (opcode == OP_AB);
    dec_done      = (opcode == OP_DONE);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in FETCH; returns with the DUT in EXEC of that instruction.
  task automatic fetch(input logic [8:0] data, input int dly, input logic [8:0] prev);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(pc));
    tick();
    for (int i = 0; i < dly; i++) begin
      imem_data = 9'h1ff;
      chk("wait_no_exec", 32'(exec_stb), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_instr_hold", 32'(instr_q), 32'(prev));
      tick();
    end
    imem_valid = 1'b1;
    imem_data  = data;
    tick();
    imem_valid = 1'b0;
    imem_data  = 9'h0aa;
    chk("exec_stb", 32'(exec_stb), 32'd1);
    chk("exec_no_mem", 32'(mem_stb), 32'd0);
    chk("instr_q", 32'(instr_q), 32'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr_q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exec", 32'(exec_stb), 32'd0);
    chk("rst_mem", 32'(mem_stb), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_cnt", 32'(cycle_count), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_req", 32'(imem_req), 32'd0);

    // Two-instruction run: 0x010 then DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(9'h010, 0, 9'h000);
    chk("run1_pc_exec", 32'(pc), 32'd0);
    tick();
    chk("run1_pc_inc", 32'(pc), 32'd1);
    fetch(9'h1f0, 0, 9'h010);
    tick();
    chk("run1_done", 32'(done), 32'd1);
    chk("run1_halt_busy", 32'(busy), 32'd0);
    chk("run1_halt_pc", 32'(pc), 32'd1);
    chk("run1_halt_exec", 32'(exec_stb), 32'd0);
    tick();
    chk("run1_done_hold", 32'(done), 32'd1);

    // Restart from HALT; delayed imem_valid; RB +5
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", 32'(pc), 32'd0);
    fetch(9'h175, 4, 9'h1f0);
    imem_valid = 1'b1;
    imem_data  = 9'h0f3;
    tick();
    imem_valid = 1'b0;
    chk("rb_pc", 32'(pc), 32'd5);
    chk("valid_ignored_exec", 32'(instr_q), 32'h175);

    // BEQ -2 taken at pc=5
    eq_flag = 1'b1;
    fetch(9'h16e, 0, 9'h175);
    tick();
    eq_flag = 1'b0;
    chk("beq_taken_pc", 32'(pc), 32'd3);
    fetch(9'h172, 0, 9'h16e);
    tick();
    chk("rb_back_pc", 32'(pc), 32'd5);
    // BEQ -2 not taken at pc=5
    fetch(9'h16e, 0, 9'h172);
    tick();
    chk("beq_nt_pc", 32'(pc), 32'd6);

    // AB operand 2 with start pulsed mid-run
    start = 1'b1;
    fetch(9'h182, 0, 9'h16e);
    tick();
    start = 1'b0;
    chk("ab2_pc", 32'(pc), 32'h120);
    chk("start_ignored_busy", 32'(busy), 32'd1);
    fetch(9'h18f, 0, 9'h182);
    tick();
    chk("ab15_pc", 32'(pc), 32'h3ff);

    // LOADM at 0x3ff: MEM cycle, PC wraps
    fetch(9'h110, 0, 9'h18f);
    tick();
    chk("load_mem_stb", 32'(mem_stb), 32'd1);
    chk("load_mem_no_exec", 32'(exec_stb), 32'd0);
    chk("load_pc_wrap", 32'(pc), 32'd0);
    tick();
    chk("load_next_fetch", 32'(imem_req), 32'd1);

    // STOREM, then reset during MEM
    fetch(9'h130, 0, 9'h110);
    tick();
    chk("store_mem_stb", 32'(mem_stb), 32'd1);
    chk("store_pc", 32'(pc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_stb", 32'(mem_stb), 32'd0);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_instr", 32'(instr_q), 32'd0);
    chk("abort_cnt", 32'(cycle_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_mem", 32'(mem_stb), 32'd0);
    chk("post_rst_exec", 32'(exec_stb), 32'd0);
    chk("post_rst_req", 32'(imem_req), 32'd0);

    // Load then DONE: 7 busy cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(9'h110, 0, 9'h000);
    tick();
    chk("run2_mem_stb", 32'(mem_stb), 32'd1);
    tick();
    fetch(9'h1f0, 0, 9'h110);
    tick();
    chk("run2_done", 32'(done), 32'd1);
    chk("run2_pc", 32'(pc), 32'd1);
`ifdef SEQ_CYCLE_COUNT_EN
    chk("run2_cnt", 32'(cycle_count), 32'd7);
    tick();
    chk("run2_cnt_hold", 32'(cycle_count), 32'd7);
`else
    chk("run2_cnt_tied", 32'(cycle_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
